// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and types for the MIPS core
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int NUM_CNTS   = 8;

  typedef enum logic [2:0] {
    CNT_RTYPE = 3'd0,
    CNT_LW    = 3'd1,
    CNT_SW    = 3'd2,
    CNT_J     = 3'd3,
    CNT_BEQ   = 3'd4,
    CNT_BNE   = 3'd5,
    CNT_NOP   = 3'd6,
    CNT_TOTAL = 3'd7
  } cnt_sel_e;

endpackage

// File: rtl/wb_retire_counters.sv
// rtl/wb_retire_counters.sv - per-class retirement counters with registered readout
module wb_retire_counters
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       class_i,
  input  logic             cnt_clear_i,
  input  logic [2:0]       cnt_sel_i,
  output logic [CNT_W-1:0] cnt_value_o
);

  logic [CNT_W-1:0] cnt_q [NUM_CNTS];
  logic [CNT_W-1:0] cnt_d [NUM_CNTS];
  logic [CNT_W-1:0] cnt_value_q;
  logic             any_retire;

  // nop retires an instruction slot but is not counted in the total
  assign any_retire = |class_i[5:0];

  always_comb begin
    for (int i = 0; i < NUM_CNTS; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (cnt_clear_i) begin
      for (int i = 0; i < NUM_CNTS; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < int'(CNT_TOTAL); i++) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(class_i[i]);
      end
      cnt_d[CNT_TOTAL] = cnt_q[CNT_TOTAL] + CNT_W'(any_retire);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNTS; i++) begin
        cnt_q[i] <= '0;
      end
      cnt_value_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CNTS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      cnt_value_q <= cnt_q[cnt_sel_i];
    end
  end

  assign cnt_value_o = cnt_value_q;

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back stage and 32-entry register file with write-through bypass
module wb_regfile
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_mem_to_reg,
  input  logic                  wb_reg_write,
  input  logic [DATA_W-1:0]     wb_read_data,
  input  logic [DATA_W-1:0]     wb_address,
  input  logic [REG_ADDR_W-1:0] wb_reg_dest,
  input  logic                  wb_rtype,
  input  logic                  wb_lw,
  input  logic                  wb_sw,
  input  logic                  wb_j,
  input  logic                  wb_beq,
  input  logic                  wb_bne,
  input  logic                  wb_nop,
  input  logic [REG_ADDR_W-1:0] rd_addr1,
  input  logic [REG_ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0]     rd_data1,
  output logic [DATA_W-1:0]     rd_data2,
  output logic [DATA_W-1:0]     wb_data,
  input  logic [2:0]            cnt_sel,
  input  logic                  cnt_clear,
  output logic [CNT_W-1:0]      cnt_value
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;

  assign wb_data = wb_mem_to_reg ? wb_read_data : wb_address;
  assign wr_en   = wb_reg_write && (wb_reg_dest != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wb_reg_dest] <= wb_data;
    end
  end

  // r0 check comes first so a bypassed write can never leak onto a read of r0
  assign rd_data1 = (rd_addr1 == '0)                   ? '0      :
                    (wr_en && rd_addr1 == wb_reg_dest) ? wb_data : regs_q[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0)                   ? '0      :
                    (wr_en && rd_addr2 == wb_reg_dest) ? wb_data : regs_q[rd_addr2];

  wb_retire_counters #(
    .CNT_W(CNT_W)
  ) u_counters (
    .clk         (clk),
    .rst         (rst),
    .class_i     ({wb_nop, wb_bne, wb_beq, wb_j, wb_sw, wb_lw, wb_rtype}),
    .cnt_clear_i (cnt_clear),
    .cnt_sel_i   (cnt_sel),
    .cnt_value_o (cnt_value)
  );

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile against a behavioural model
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_mem_to_reg, wb_reg_write;
  logic [31:0] wb_read_data, wb_address;
  logic [4:0]  wb_reg_dest, rd_addr1, rd_addr2;
  logic [6:0]  flags;
  logic [2:0]  cnt_sel;
  logic        cnt_clear;
  logic [31:0] rd_data1, rd_data2, wb_data, cnt_value;
  logic [31:0] rd_data1_n, rd_data2_n, wb_data_n;
  logic [3:0]  cnt_value4;

  logic [31:0] mregs [32];
  logic [31:0] mcnt  [8];
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_read_data(wb_read_data), .wb_address(wb_address), .wb_reg_dest(wb_reg_dest),
    .wb_rtype(flags[0]), .wb_lw(flags[1]), .wb_sw(flags[2]), .wb_j(flags[3]),
    .wb_beq(flags[4]), .wb_bne(flags[5]), .wb_nop(flags[6]),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_data(wb_data), .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_value(cnt_value)
  );

  wb_regfile #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_read_data(wb_read_data), .wb_address(wb_address), .wb_reg_dest(wb_reg_dest),
    .wb_rtype(flags[0]), .wb_lw(flags[1]), .wb_sw(flags[2]), .wb_j(flags[3]),
    .wb_beq(flags[4]), .wb_bne(flags[5]), .wb_nop(flags[6]),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1_n), .rd_data2(rd_data2_n),
    .wb_data(wb_data_n), .cnt_sel(cnt_sel), .cnt_clear(cnt_clear), .cnt_value(cnt_value4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear_all();
    for (int k = 0; k < 32; k++) mregs[k] = '0;
    for (int k = 0; k < 8; k++) mcnt[k] = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    logic [31:0] wd;
    wd = wb_mem_to_reg ? wb_read_data : wb_address;
    if (a == 5'd0) return 32'd0;
    if (wb_reg_write && wb_reg_dest != 5'd0 && a == wb_reg_dest) return wd;
    return mregs[a];
  endfunction

  task automatic check_ports();
    #1;
    chk("wb_data", wb_data, wb_mem_to_reg ? wb_read_data : wb_address);
    chk("rd_data1", rd_data1, model_read(rd_addr1));
    chk("rd_data2", rd_data2, model_read(rd_addr2));
  endtask

  // Applies one clock edge to the model using the pre-edge inputs, then checks readout
  task automatic step();
    logic [31:0] e;
    e = rst ? 32'd0 : mcnt[cnt_sel];
    if (!rst) begin
      if (wb_reg_write && wb_reg_dest != 5'd0)
        mregs[wb_reg_dest] = wb_mem_to_reg ? wb_read_data : wb_address;
      if (cnt_clear) begin
        for (int k = 0; k < 8; k++) mcnt[k] = '0;
      end else begin
        for (int k = 0; k < 7; k++) mcnt[k] = mcnt[k] + {31'd0, flags[k]};
        if (flags[5:0] != 6'd0) mcnt[7] = mcnt[7] + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    chk("cnt_value", cnt_value, e);
    chk("cnt_value_w4", {28'd0, cnt_value4}, e & 32'hF);
  endtask

  task automatic drive(input logic we, input logic mtr, input logic [31:0] rdat,
                       input logic [31:0] addr, input logic [4:0] dest);
    wb_reg_write = we; wb_mem_to_reg = mtr; wb_read_data = rdat;
    wb_address = addr; wb_reg_dest = dest;
  endtask

  task automatic reads(input logic [4:0] a1, input logic [4:0] a2);
    rd_addr1 = a1; rd_addr2 = a2;
  endtask

  initial begin
    rst = 1'b1; flags = '0; cnt_sel = '0; cnt_clear = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0); reads(5'd5, 5'd0);
    model_clear_all();
    #2;
    chk("reset_rd1", rd_data1, 32'd0);
    chk("reset_cnt", cnt_value, 32'd0);
    rst = 1'b0;
    check_ports();

    // write r5 with an rtype retiring, then verify and reset asynchronously
    drive(1'b1, 1'b0, 32'hAAAA_AAAA, 32'h0000_1234, 5'd5); flags = 7'b0000001;
    step();
    drive(1'b0, 1'b0, '0, '0, '0); flags = '0;
    check_ports();
    chk("r5_written", rd_data1, 32'h0000_1234);
    step();
    chk("pre_rst_cnt", cnt_value, 32'd1);
    rst = 1'b1; model_clear_all();
    #2;
    chk("rst_async_rd1", rd_data1, 32'd0);
    chk("rst_async_cnt", cnt_value, 32'd0);
    drive(1'b1, 1'b0, '0, 32'h55, 5'd6); reads(5'd5, 5'd6);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    check_ports();
    chk("rst_drop_write", rd_data2, 32'd0);

    // write via ALU result then via load data
    drive(1'b1, 1'b0, 32'h1111_1111, 32'hDEAD_BEEF, 5'd7); step();
    drive(1'b1, 1'b1, 32'h0000_CAFE, 32'h2222_2222, 5'd8); step();
    drive(1'b0, 1'b0, '0, '0, '0); reads(5'd7, 5'd8);
    check_ports();
    chk("r7_alu", rd_data1, 32'hDEAD_BEEF);
    chk("r8_load", rd_data2, 32'h0000_CAFE);

    // r0 is never written and never bypassed
    drive(1'b1, 1'b0, '0, 32'hFFFF_FFFF, 5'd0); reads(5'd0, 5'd0);
    check_ports();
    chk("r0_same_cycle", rd_data1, 32'd0);
    step();
    drive(1'b0, 1'b0, '0, '0, '0);
    check_ports();
    chk("r0_later", rd_data1, 32'd0);

    // bypass versus stored value
    drive(1'b1, 1'b0, '0, 32'h11, 5'd3); step();
    drive(1'b1, 1'b0, '0, 32'h22, 5'd3); reads(5'd3, 5'd3);
    check_ports();
    chk("bypass_p1", rd_data1, 32'h22);
    chk("bypass_p2", rd_data2, 32'h22);
    wb_reg_write = 1'b0;
    check_ports();
    chk("no_bypass_p1", rd_data1, 32'h11);
    chk("no_bypass_p2", rd_data2, 32'h11);

    // counter scenario
    cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
    flags = 7'b0000001; repeat (3) step();
    flags = 7'b0000010; repeat (2) step();
    flags = 7'b0010010; step();
    flags = 7'b1000000; repeat (2) step();
    flags = '0;
    cnt_sel = 3'd7; step(); chk("cnt_total", cnt_value, 32'd6);
    cnt_sel = 3'd0; step(); chk("cnt_rtype", cnt_value, 32'd3);
    cnt_sel = 3'd1; step(); chk("cnt_lw", cnt_value, 32'd3);
    cnt_sel = 3'd4; step(); chk("cnt_beq", cnt_value, 32'd1);
    cnt_sel = 3'd6; step(); chk("cnt_nop", cnt_value, 32'd2);
    cnt_sel = 3'd2; step(); chk("cnt_sw", cnt_value, 32'd0);
    cnt_sel = 3'd0; flags = 7'b0000001; cnt_clear = 1'b1; step();
    flags = '0; cnt_clear = 1'b0;
    step(); chk("clear_wins_rtype", cnt_value, 32'd0);
    cnt_sel = 3'd7; step(); chk("clear_total", cnt_value, 32'd0);

    // wrap at 4 bits: 17 increments leave 1
    cnt_sel = 3'd0; flags = 7'b0000001; repeat (17) step();
    flags = '0; step();
    chk("wrap_w4", {28'd0, cnt_value4}, 32'd1);
    chk("nowrap_w32", cnt_value, 32'd17);

    // randomized traffic, with occasional clears and mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 3) != 0), $urandom_range(0, 1), $urandom, $urandom,
            ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
      reads(5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7)));
      for (int k = 0; k < 7; k++) flags[k] = ($urandom_range(0, 2) == 0);
      cnt_sel = 3'($urandom);
      cnt_clear = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1; model_clear_all();
        check_ports();
        chk("rand_rst_cnt", cnt_value, 32'd0);
        step();
        rst = 1'b0;
      end else begin
        check_ports();
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
